// File: rtl/scan_run_level.sv
// Captures one quantized 8x8 block, emits its DC coefficient once, then walks the
// 63 AC positions in progressive scan order emitting (run, |level|, sign) pairs.
module scan_run_level #(
    parameter int COEFF_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COEFF_WIDTH-1:0] input_data_array [8][8],
    output logic                   busy,
    output logic                   dc_valid,
    output logic [COEFF_WIDTH-1:0] dc_coeff,
    output logic                   ac_valid,
    input  logic                   ac_ready,
    output logic [5:0]             ac_run,
    output logic [COEFF_WIDTH-1:0] ac_abs_level,
    output logic                   ac_sign,
    output logic                   block_done,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {IDLE, DC, SCAN, DONE} state_t;

    // Scan position -> raster index (row*8 + col).
    localparam int SCAN_ORDER [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
    localparam logic [COEFF_WIDTH-1:0] ONE = 1;

    state_t                 state, state_next;
    logic [5:0]             idx, idx_next;
    logic [5:0]             run, run_next;
    logic                   capture;
    logic [COEFF_WIDTH-1:0] buffer [8][8];
    logic [5:0]             raster;
    logic [COEFF_WIDTH-1:0] coeff;
    logic                   coeff_nz;
    logic [COEFF_WIDTH-1:0] magnitude;

    assign raster    = SCAN_ORDER[idx][5:0];
    assign coeff     = buffer[raster[5:3]][raster[2:0]];
    assign coeff_nz  = |coeff;
    // Unsigned negation: the most negative value maps to 2^(W-1) exactly.
    assign magnitude = coeff[COEFF_WIDTH-1] ? (~coeff) + ONE : coeff;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= 6'd1;
            run   <= 6'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            run   <= run_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    buffer[r][c] <= '0;
        end else if (capture) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    buffer[r][c] <= input_data_array[r][c];
        end
    end

    // AC handshake: a pair transfers on any edge where ac_valid && ac_ready; while
    // ac_valid is high and ac_ready low, every AC field holds its value.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        run_next   = run;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    idx_next   = 6'd1;
                    run_next   = 6'd0;
                    state_next = DC;
                end
            end
            DC: state_next = SCAN;
            SCAN: begin
                if (!coeff_nz || ac_ready) begin
                    run_next = coeff_nz ? 6'd0 : run + 6'd1;
                    if (idx == 6'd63) state_next = DONE;
                    else              idx_next   = idx + 6'd1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign dc_valid     = (state == DC);
    assign dc_coeff     = dc_valid ? buffer[0][0] : '0;
    assign ac_valid     = (state == SCAN) && coeff_nz;
    assign ac_run       = ac_valid ? run : 6'd0;
    assign ac_abs_level = ac_valid ? magnitude : '0;
    assign ac_sign      = ac_valid & coeff[COEFF_WIDTH-1];
    assign block_done   = (state == DONE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_scan_run_level.sv
// Bench for scan_run_level: a per-cycle behavioural model (precomputed pair list
// plus stall accounting) and literal event-timing checks on directed blocks.
module tb_scan_run_level;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          ac_ready = 1'b1;
    logic [W-1:0]  data [8][8];
    logic          busy, dc_valid, ac_valid, ac_sign, block_done;
    logic [W-1:0]  dc_coeff, ac_abs_level;
    logic [5:0]    ac_run;
    logic [1:0]    fsm_state;

    scan_run_level #(.COEFF_WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .input_data_array(data), .busy(busy), .dc_valid(dc_valid),
        .dc_coeff(dc_coeff), .ac_valid(ac_valid), .ac_ready(ac_ready),
        .ac_run(ac_run), .ac_abs_level(ac_abs_level), .ac_sign(ac_sign),
        .block_done(block_done), .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int scan_tab [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct { int pos; int run; longint lvl; bit sgn; } pair_t;
    pair_t  pq [$];
    bit     m_busy = 0;
    int     m_a = 0;
    int     m_stalls = 0;
    longint m_dc = 0;

    function automatic void model_accept();
        int     run;
        longint v;
        pair_t  p;
        m_busy = 1; m_a = cyc; m_stalls = 0;
        m_dc = longint'(data[0][0]);
        pq.delete();
        run = 0;
        for (int k = 1; k < 64; k++) begin
            v = longint'($signed(data[scan_tab[k] / 8][scan_tab[k] % 8]));
            if (v == 0) run++;
            else begin
                p.pos = k; p.run = run; p.lvl = (v < 0) ? -v : v; p.sgn = (v < 0);
                pq.push_back(p);
                run = 0;
            end
        end
    endfunction

    // Observed event log for literal checks (kind 0 = dc, 1 = ac handshake, 2 = done).
    typedef struct { int rel; int kind; int run; longint lvl; int sgn; } ev_t;
    ev_t log_q [$];
    int  t0 = 0;

    always @(negedge clock) begin : compare
        int     rel;
        bit     e_busy, e_dcv, e_acv, e_done, e_sgn;
        longint e_dc, e_lvl;
        int     e_run, e_state;
        ev_t    ev;
        e_busy = 0; e_dcv = 0; e_acv = 0; e_done = 0; e_sgn = 0;
        e_dc = 0; e_lvl = 0; e_run = 0; e_state = 0; rel = 0;
        if (!reset_n) begin
            m_busy = 0;
            pq.delete();
        end else if (m_busy) begin
            rel = cyc - m_a - m_stalls;
            e_busy = 1;
            e_state = 2;
            if (rel == 1) begin
                e_dcv = 1; e_dc = m_dc; e_state = 1;
            end else if (rel == 65) begin
                e_done = 1; e_state = 3;
            end else if (pq.size() > 0 && pq[0].pos == rel - 1) begin
                e_acv = 1; e_run = pq[0].run; e_lvl = pq[0].lvl; e_sgn = pq[0].sgn;
            end
        end
        chk("busy", busy, e_busy);
        chk("dc_valid", dc_valid, e_dcv);
        chk("dc_coeff", dc_coeff, e_dc);
        chk("ac_valid", ac_valid, e_acv);
        chk("ac_run", ac_run, e_run);
        chk("ac_abs_level", ac_abs_level, e_lvl);
        chk("ac_sign", ac_sign, e_sgn);
        chk("block_done", block_done, e_done);
        chk("fsm_state", fsm_state, e_state);

        if (reset_n) begin
            ev.rel = cyc - t0; ev.run = 0; ev.lvl = 0; ev.sgn = 0;
            if (dc_valid) begin ev.kind = 0; ev.lvl = longint'(dc_coeff); log_q.push_back(ev); end
            if (ac_valid && ac_ready) begin
                ev.kind = 1; ev.run = ac_run; ev.lvl = longint'(ac_abs_level); ev.sgn = ac_sign;
                log_q.push_back(ev);
            end
            if (block_done) begin ev.kind = 2; ev.run = 0; ev.lvl = 0; ev.sgn = 0; log_q.push_back(ev); end

            if (m_busy) begin
                if (e_acv) begin
                    if (ac_ready) void'(pq.pop_front());
                    else          m_stalls++;
                end
                if (e_done) m_busy = 0;
            end else if (start) begin
                model_accept();
            end
        end
    end

    function automatic void check_ev(string name, int i, int rel, int kind, int run, longint lvl, int sgn);
        checks++;
        if (i >= log_q.size()) begin
            errors++;
            $display("FAIL %s: event %0d absent (%0d logged), want rel=%0d kind=%0d", name, i, log_q.size(), rel, kind);
        end else if (log_q[i].rel != rel || log_q[i].kind != kind || log_q[i].run != run ||
                     log_q[i].lvl != lvl || log_q[i].sgn != sgn) begin
            errors++;
            $display("FAIL %s: got rel=%0d kind=%0d run=%0d lvl=%0d sgn=%0d, want rel=%0d kind=%0d run=%0d lvl=%0d sgn=%0d",
                     name, log_q[i].rel, log_q[i].kind, log_q[i].run, log_q[i].lvl, log_q[i].sgn,
                     rel, kind, run, lvl, sgn);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_data();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                data[r][c] = '0;
    endtask

    task automatic set_t3(input logic [W-1:0] dcv);
        clear_data();
        data[0][0] = dcv;
        data[0][1] = 32'd3;
        data[1][0] = -32'sd2;
        data[0][2] = 32'd7;
    endtask

    task automatic fill_random(input int pct);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                data[r][c] = '0;
                if ($urandom_range(0, 99) < pct) begin
                    case ($urandom_range(0, 3))
                        0: data[r][c] = $urandom;
                        1: data[r][c] = W'($urandom_range(1, 200));
                        2: data[r][c] = -W'($urandom_range(1, 200));
                        default: data[r][c] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                    endcase
                end
            end
    endtask

    // ready_mode: 0 always ready, 1 low for rel stall_lo..stall_hi, 2 random.
    task automatic run_block(input int ready_mode, input int stall_lo, input int stall_hi,
                             input int restart_rel, input int chain_rel, input int reset_rel,
                             input int max_cycles);
        log_q.delete();
        @(posedge clock); #1;
        t0 = cyc; start = 1'b1; ac_ready = 1'b1;
        for (int r = 1; r <= max_cycles; r++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (r == restart_rel) begin set_t3(32'd9); start = 1'b1; end
            if (r == chain_rel) start = 1'b1;
            case (ready_mode)
                0: ac_ready = 1'b1;
                1: ac_ready = !(r >= stall_lo && r <= stall_hi);
                default: ac_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (r == reset_rel + 2) reset_n = 1'b1;
            if (r == reset_rel) begin
                #2 reset_n = 1'b0;
                #1 chk("reset_async_zero",
                       {busy, dc_valid, ac_valid, block_done, ac_sign, ac_run, dc_coeff, ac_abs_level}, 0);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : watchdog
        #500000;
        errors++; checks++;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        clear_data();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", {busy, dc_valid, ac_valid, block_done, ac_sign, ac_run, dc_coeff, ac_abs_level}, 0);
        chk("reset_state", fsm_state, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // All AC zero, DC 1023.
        clear_data(); data[0][0] = 32'd1023;
        run_block(0, 0, 0, -1, -1, -1, 75);
        check_ev("t1_dc", 0, 1, 0, 0, 1023, 0);
        check_ev("t1_done", 1, 65, 2, 0, 0, 0);
        chk("t1_events", log_q.size(), 2);

        // Only [7][7] = -5: last scan position, run 62.
        clear_data(); data[7][7] = -32'sd5;
        run_block(0, 0, 0, -1, -1, -1, 75);
        check_ev("t2_pair", 1, 64, 1, 62, 5, 1);
        check_ev("t2_done", 2, 65, 2, 0, 0, 0);

        // Three nonzero early coefficients.
        set_t3(32'd0);
        run_block(0, 0, 0, -1, -1, -1, 75);
        check_ev("t3_p0", 1, 2, 1, 0, 3, 0);
        check_ev("t3_p1", 2, 3, 1, 0, 2, 1);
        check_ev("t3_p2", 3, 5, 1, 1, 7, 0);
        check_ev("t3_done", 4, 65, 2, 0, 0, 0);

        // Same block with ready low for three cycles.
        set_t3(32'd0);
        run_block(1, 2, 4, -1, -1, -1, 75);
        check_ev("t4_p0", 1, 5, 1, 0, 3, 0);
        check_ev("t4_p1", 2, 6, 1, 0, 2, 1);
        check_ev("t4_p2", 3, 8, 1, 1, 7, 0);
        check_ev("t4_done", 4, 68, 2, 0, 0, 0);

        // Start while busy ignored (with new data); back-to-back start after done.
        clear_data(); data[0][0] = 32'd1023;
        run_block(0, 0, 0, 10, 66, -1, 140);
        check_ev("t5_dc", 0, 1, 0, 0, 1023, 0);
        check_ev("t5_done", 1, 65, 2, 0, 0, 0);
        check_ev("t5_dc2", 2, 67, 0, 0, 9, 0);
        check_ev("t5_p2", 5, 71, 1, 1, 7, 0);
        check_ev("t5_done2", 6, 131, 2, 0, 0, 0);

        // Reset mid-block: no block_done, then a clean block.
        set_t3(32'd0);
        run_block(0, 0, 0, -1, -1, 20, 30);
        chk("t6_no_done_events", log_q.size(), 4);
        set_t3(32'd0);
        run_block(0, 0, 0, -1, -1, -1, 75);
        check_ev("t6_p2", 3, 5, 1, 1, 7, 0);
        check_ev("t6_done", 4, 65, 2, 0, 0, 0);

        // Most negative coefficient magnitude.
        clear_data(); data[0][1] = 32'h8000_0000;
        run_block(0, 0, 0, -1, -1, -1, 75);
        check_ev("t7_minneg", 1, 2, 1, 0, 64'h8000_0000, 1);

        // Randomized blocks with random backpressure, checked by the model.
        for (int b = 0; b < 8; b++) begin
            fill_random((b == 0) ? 100 : $urandom_range(0, 60));
            run_block(2, 0, 0, -1, -1, -1, 250);
            chk("rand_done_seen", (log_q.size() > 0) ? log_q[log_q.size()-1].kind : -1, 2);
        end

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
